// File: rtl/junction_controller.sv
// Two-road junction sequencer: demand-driven main/side UK light sequences with an all-red pedestrian walk phase.
// Lamps are registered from the next-state decode so they change on the same edge as the state.
module junction_controller #(
    parameter int unsigned T_ALLRED    = 1,
    parameter int unsigned T_RA        = 2,
    parameter int unsigned T_AMBER     = 3,
    parameter int unsigned T_MIN_GREEN = 8,
    parameter int unsigned T_SIDE_G    = 6,
    parameter int unsigned T_WALK      = 5,
    parameter int unsigned CW          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ped_req,
    input  logic side_car,
    output logic main_red,
    output logic main_amber,
    output logic main_green,
    output logic side_red,
    output logic side_amber,
    output logic side_green,
    output logic walk,
    output logic ped_wait
);

    typedef enum logic [3:0] {
        AR_M, M_RA, M_G, M_A, AR_S, S_RA, S_G, S_A, WALK
    } state_t;

    localparam logic [CW-1:0] C_ALLRED = CW'(T_ALLRED - 1);
    localparam logic [CW-1:0] C_RA     = CW'(T_RA - 1);
    localparam logic [CW-1:0] C_AMBER  = CW'(T_AMBER - 1);
    localparam logic [CW-1:0] C_MING   = CW'(T_MIN_GREEN - 1);
    localparam logic [CW-1:0] C_SIDEG  = CW'(T_SIDE_G - 1);
    localparam logic [CW-1:0] C_WALK   = CW'(T_WALK - 1);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_ped_wait;
    logic            r_from_side;
    logic [6:0]      r_lamps;
    logic [6:0]      w_lamps;

    always_comb begin
        w_next = r_state;
        case (r_state)
            AR_M: if (r_cnt == C_ALLRED) w_next = r_ped_wait ? WALK : M_RA;
            M_RA: if (r_cnt == C_RA)     w_next = M_G;
            M_G:  if (r_cnt >= C_MING && (side_car || r_ped_wait)) w_next = M_A;
            M_A:  if (r_cnt == C_AMBER)  w_next = AR_S;
            AR_S: if (r_cnt == C_ALLRED) w_next = r_ped_wait ? WALK : S_RA;
            S_RA: if (r_cnt == C_RA)     w_next = S_G;
            // Side green ends at its maximum, or early once the sensor clears after the first cycle
            S_G:  if (r_cnt == C_SIDEG || (r_cnt != '0 && !side_car)) w_next = S_A;
            S_A:  if (r_cnt == C_AMBER)  w_next = AR_M;
            WALK: if (r_cnt == C_WALK)   w_next = (r_from_side && side_car) ? S_RA : M_RA;
            default: w_next = AR_M;
        endcase
    end

    // Lamp order: main r/a/g, side r/a/g, walk
    always_comb begin
        w_lamps = 7'b1001000;
        case (w_next)
            M_RA:    w_lamps = 7'b1101000;
            M_G:     w_lamps = 7'b0011000;
            M_A:     w_lamps = 7'b0101000;
            S_RA:    w_lamps = 7'b1001100;
            S_G:     w_lamps = 7'b1000010;
            S_A:     w_lamps = 7'b1000100;
            WALK:    w_lamps = 7'b1001001;
            default: w_lamps = 7'b1001000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= AR_M;
            r_cnt       <= '0;
            r_ped_wait  <= 1'b0;
            r_from_side <= 1'b0;
            r_lamps     <= 7'b1001000;
        end else begin
            r_state <= w_next;
            r_lamps <= w_lamps;
            if (w_next != r_state) begin
                r_cnt <= '0;
                if (w_next == AR_M) r_from_side <= 1'b0;
                if (w_next == AR_S) r_from_side <= 1'b1;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Entering WALK clears the request even if the button is pressed on that edge
            if (r_state != WALK) begin
                if (w_next == WALK)  r_ped_wait <= 1'b0;
                else if (ped_req)    r_ped_wait <= 1'b1;
            end
        end
    end

    assign {main_red, main_amber, main_green, side_red, side_amber, side_green, walk} = r_lamps;
    assign ped_wait = r_ped_wait;

endmodule

// File: tb/tb_junction_controller.sv
// Directed bench for junction_controller: phase-timeline model with per-cycle compare and safety checks.
module tb_junction_controller;

    localparam int T_ALLRED = 1, T_RA = 2, T_AMBER = 3, T_MIN_GREEN = 8, T_SIDE_G = 6, T_WALK = 5;

    localparam logic [6:0] P_AR   = 7'b1001000;
    localparam logic [6:0] P_MRA  = 7'b1101000;
    localparam logic [6:0] P_MG   = 7'b0011000;
    localparam logic [6:0] P_MA   = 7'b0101000;
    localparam logic [6:0] P_SRA  = 7'b1001100;
    localparam logic [6:0] P_SG   = 7'b1000010;
    localparam logic [6:0] P_SA   = 7'b1000100;
    localparam logic [6:0] P_WK   = 7'b1001001;

    logic clk = 1'b0;
    logic rst_n, ped_req, side_car;
    logic main_red, main_amber, main_green, side_red, side_amber, side_green, walk, ped_wait;
    logic [6:0] lamps;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    junction_controller #(
        .T_ALLRED(1), .T_RA(2), .T_AMBER(3), .T_MIN_GREEN(8), .T_SIDE_G(6), .T_WALK(5), .CW(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ped_req(ped_req), .side_car(side_car),
        .main_red(main_red), .main_amber(main_amber), .main_green(main_green),
        .side_red(side_red), .side_amber(side_amber), .side_green(side_green),
        .walk(walk), .ped_wait(ped_wait)
    );

    assign lamps = {main_red, main_amber, main_green, side_red, side_amber, side_green, walk};

    // Model: phase timeline with "cycles spent" in the current phase
    typedef enum int {H_ARM, H_MRA, H_MG, H_MA, H_ARS, H_SRA, H_SG, H_SA, H_WALK} ph_t;
    ph_t m_ph;
    int  m_age;
    bit  m_pend, m_side;

    function automatic logic [6:0] pat_of(input ph_t p);
        case (p)
            H_MRA:  return P_MRA;
            H_MG:   return P_MG;
            H_MA:   return P_MA;
            H_SRA:  return P_SRA;
            H_SG:   return P_SG;
            H_SA:   return P_SA;
            H_WALK: return P_WK;
            default: return P_AR;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        ph_t nx;
        int  spent;
        if (!rst_n) begin
            m_ph <= H_ARM; m_age <= 0; m_pend <= 1'b0; m_side <= 1'b0;
        end else begin
            nx = m_ph;
            spent = m_age + 1;
            case (m_ph)
                H_ARM:  if (spent >= T_ALLRED) nx = m_pend ? H_WALK : H_MRA;
                H_MRA:  if (spent >= T_RA) nx = H_MG;
                H_MG:   if (spent >= T_MIN_GREEN && (side_car || m_pend)) nx = H_MA;
                H_MA:   if (spent >= T_AMBER) nx = H_ARS;
                H_ARS:  if (spent >= T_ALLRED) nx = m_pend ? H_WALK : H_SRA;
                H_SRA:  if (spent >= T_RA) nx = H_SG;
                H_SG:   if (spent >= T_SIDE_G || (spent >= 2 && !side_car)) nx = H_SA;
                H_SA:   if (spent >= T_AMBER) nx = H_ARM;
                H_WALK: if (spent >= T_WALK) nx = (m_side && side_car) ? H_SRA : H_MRA;
                default: nx = H_ARM;
            endcase
            m_age <= (nx != m_ph) ? 0 : spent;
            if (nx == H_ARS) m_side <= 1'b1;
            else if (nx == H_ARM) m_side <= 1'b0;
            if (m_ph != H_WALK) begin
                if (nx == H_WALK) m_pend <= 1'b0;
                else if (ped_req) m_pend <= 1'b1;
            end
            m_ph <= nx;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit road_ok(input logic [2:0] rag);
        return rag == 3'b100 || rag == 3'b110 || rag == 3'b001 || rag == 3'b010;
    endfunction

    always @(negedge clk) begin
        chk("model_lamps", {25'd0, lamps}, {25'd0, pat_of(m_ph)});
        chk("model_ped_wait", {31'd0, ped_wait}, {31'd0, m_pend});
        chk("safety", {31'd0, road_ok(lamps[6:4]) && road_ok(lamps[3:1]) && (main_red || side_red)
                       && (!walk || (main_red && side_red))}, 32'd1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic run_len(input logic [6:0] pat, output int n);
        n = 0;
        while (lamps === pat && n < 300) begin
            n++;
            tick(1);
        end
    endtask

    task automatic wait_pat(input string nm, input logic [6:0] pat);
        int n;
        n = 0;
        while (lamps !== pat && n < 300) begin
            n++;
            tick(1);
        end
        chk(nm, {25'd0, lamps}, {25'd0, pat});
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ped_req = 1'b0; side_car = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n = 1'b1; ped_req = 1'b0; side_car = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_lamps", {25'd0, lamps}, {25'd0, P_AR});
        chk("reset_ped_wait", {31'd0, ped_wait}, 32'd0);
        tick(2);
        rst_n = 1'b1;

        // No demand: all-red, 2 red+amber, then green held
        chk("nd_allred", {25'd0, lamps}, {25'd0, P_AR});
        tick(1); chk("nd_ra0", {25'd0, lamps}, {25'd0, P_MRA});
        tick(1); chk("nd_ra1", {25'd0, lamps}, {25'd0, P_MRA});
        tick(1); chk("nd_green", {25'd0, lamps}, {25'd0, P_MG});
        n = 0;
        repeat (100) begin
            if (lamps === P_MG) n++;
            tick(1);
        end
        chk("nd_hold_100", n, 100);

        // Side car from M_G cycle 5
        do_reset();
        tick(3);
        chk("sc_mg_entry", {25'd0, lamps}, {25'd0, P_MG});
        tick(5);
        side_car = 1'b1;
        run_len(P_MG, n);  chk("sc_main_green_len", 5 + n, 8);
        run_len(P_MA, n);  chk("sc_main_amber_len", n, 3);
        run_len(P_AR, n);  chk("sc_allred_len", n, 1);
        run_len(P_SRA, n); chk("sc_side_ra_len", n, 2);
        run_len(P_SG, n);  chk("sc_side_green_len", n, 6);
        run_len(P_SA, n);  chk("sc_side_amber_len", n, 3);
        run_len(P_AR, n);  chk("sc_back_arm_len", n, 1);

        // Side car leaves on the 3rd side-green cycle
        run_len(P_MRA, n); chk("el_mra_len", n, 2);
        run_len(P_MG, n);  chk("el_mg_len", n, 8);
        run_len(P_MA, n);
        run_len(P_AR, n);
        run_len(P_SRA, n);
        chk("el_sg_entry", {25'd0, lamps}, {25'd0, P_SG});
        tick(2);
        side_car = 1'b0;
        tick(1);
        chk("el_early_amber", {25'd0, lamps}, {25'd0, P_SA});

        // Pedestrian pulse at M_G cnt=10
        do_reset();
        tick(13);
        ped_req = 1'b1;
        tick(1);
        ped_req = 1'b0;
        chk("pd_wait_set", {31'd0, ped_wait}, 32'd1);
        chk("pd_still_green", {25'd0, lamps}, {25'd0, P_MG});
        tick(1);
        run_len(P_MA, n);  chk("pd_amber_len", n, 3);
        run_len(P_AR, n);  chk("pd_allred_len", n, 1);
        chk("pd_wait_clr", {31'd0, ped_wait}, 32'd0);
        run_len(P_WK, n);  chk("pd_walk_len", n, 5);
        chk("pd_after_walk", {25'd0, lamps}, {25'd0, P_MRA});

        // ped_req held through WALK: only one walk
        do_reset();
        tick(3);
        ped_req = 1'b1;
        wait_pat("hw_reach_walk", P_WK);
        run_len(P_WK, n);  chk("hw_walk_len", n, 5);
        ped_req = 1'b0;
        chk("hw_wait_clear", {31'd0, ped_wait}, 32'd0);
        n = 0;
        repeat (40) begin
            if (walk === 1'b1) n++;
            tick(1);
        end
        chk("hw_no_second_walk", n, 0);

        // ped_req on the WALK entry edge
        do_reset();
        tick(3);
        ped_req = 1'b1;
        tick(1);
        ped_req = 1'b0;
        wait_pat("ee_reach_ars", P_AR);
        ped_req = 1'b1;
        tick(1);
        ped_req = 1'b0;
        chk("ee_walk", {25'd0, lamps}, {25'd0, P_WK});
        chk("ee_wait_zero", {31'd0, ped_wait}, 32'd0);
        run_len(P_WK, n);  chk("ee_walk_len", n, 5);

        // Asynchronous reset during side green
        do_reset();
        side_car = 1'b1;
        wait_pat("mr_reach_sg", P_SG);
        ped_req = 1'b1;
        tick(1);
        ped_req = 1'b0;
        chk("mr_wait_pre", {31'd0, ped_wait}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_lamps", {25'd0, lamps}, {25'd0, P_AR});
        chk("mr_ped_wait", {31'd0, ped_wait}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        side_car = 1'b0;
        tick(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
